// File: rtl/nn_seq_pkg.sv
// Shared types and sizing for the inference sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_seq_pkg;

    localparam int NUM_NEURONS      = 10;
    localparam int WORDS_PER_NEURON = 392;
    localparam int PIXEL_WORDS      = 196;
    localparam int MAX_WEIGHT_ADDR  = NUM_NEURONS * WORDS_PER_NEURON - 1;

    // Bit positions inside the Avalon control register.
    localparam int START_BIT = 3;
    localparam int CLEAR_BIT = 0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREP     = 3'd1,
        STREAM   = 3'd2,
        DRAIN    = 3'd3,
        WAIT_ACC = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic vld;
        logic half;
        logic last;
    } beat_tag_t;

endpackage

// File: rtl/nn_read_pipe.sv
// Delays the per-issue beat tag so it lines up with SRAM read data.
// Latency: READ_LATENCY cycles.
// Backpressure: none; flush_i empties every stage.
module nn_read_pipe
    import nn_seq_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      flush_i,
    input  beat_tag_t tag_i,
    output beat_tag_t tag_o
);

    beat_tag_t stage_q [READ_LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) stage_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < READ_LATENCY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < READ_LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_o = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/nn_compute_sequencer.sv
// Drives one inference pass: SRAM reads, MAC beats, and arg-max over neuron sums.
// Latency: beats emerge READ_LATENCY cycles after each read issue.
// Backpressure: none toward SRAM/MAC; waits indefinitely for acc_valid per neuron.
module nn_compute_sequencer #(
    parameter int NUM_NEURONS      = nn_seq_pkg::NUM_NEURONS,
    parameter int WORDS_PER_NEURON = nn_seq_pkg::WORDS_PER_NEURON,
    parameter int PIXEL_WORDS      = nn_seq_pkg::PIXEL_WORDS,
    parameter int READ_LATENCY     = 1,
    parameter int ACC_W            = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clear,
    output logic             r_enable,
    output logic [11:0]      weight_address,
    output logic [9:0]       pixel_address1,
    output logic [9:0]       pixel_address2,
    input  logic [31:0]      weight_value,
    input  logic [15:0]      pixel_value1,
    input  logic [15:0]      pixel_value2,
    output logic             mac_clear,
    output logic             mac_valid,
    output logic             mac_last,
    output logic [15:0]      mac_pixels,
    output logic [31:0]      mac_weights,
    input  logic             acc_valid,
    input  logic [ACC_W-1:0] acc_value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       result_index,
    output logic [ACC_W-1:0] result_value
);

    import nn_seq_pkg::*;

    localparam logic [9:0]  P_LAST = 10'(PIXEL_WORDS - 1);
    localparam logic [3:0]  N_LAST = 4'(NUM_NEURONS - 1);
    localparam logic [11:0] W_MAX  = 12'(NUM_NEURONS * WORDS_PER_NEURON - 1);

    seq_state_t       state_q;
    logic [3:0]       n_q;
    logic [9:0]       p_q;
    logic             h_q;
    logic [11:0]      waddr_q;
    logic             r_enable_q;
    logic             mac_clear_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       result_index_q;
    logic [ACC_W-1:0] result_value_q;

    logic      last_issue;
    logic      acc_better;
    beat_tag_t issue_tag;
    beat_tag_t beat_tag;

    assign last_issue = (state_q == STREAM) && (p_q == P_LAST) && h_q;
    assign acc_better = (n_q == 4'd0) || ($signed(acc_value) > $signed(result_value_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            n_q            <= '0;
            p_q            <= '0;
            h_q            <= 1'b0;
            waddr_q        <= '0;
            r_enable_q     <= 1'b0;
            mac_clear_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_index_q <= '0;
            result_value_q <= '0;
        end else if (clear) begin
            state_q        <= IDLE;
            n_q            <= '0;
            p_q            <= '0;
            h_q            <= 1'b0;
            waddr_q        <= '0;
            r_enable_q     <= 1'b0;
            mac_clear_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_index_q <= '0;
            result_value_q <= '0;
        end else begin
            mac_clear_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q        <= PREP;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        n_q            <= '0;
                        waddr_q        <= '0;
                        result_index_q <= '0;
                        result_value_q <= '0;
                        mac_clear_q    <= 1'b1;
                    end
                end
                PREP: begin
                    p_q        <= '0;
                    h_q        <= 1'b0;
                    r_enable_q <= 1'b1;
                    state_q    <= STREAM;
                end
                STREAM: begin
                    h_q <= ~h_q;
                    if (h_q && !last_issue) p_q <= p_q + 10'd1;
                    // Weight address runs across neurons and parks on the final word.
                    if (waddr_q != W_MAX) waddr_q <= waddr_q + 12'd1;
                    if (last_issue) begin
                        r_enable_q <= 1'b0;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (beat_tag.vld && beat_tag.last) state_q <= WAIT_ACC;
                end
                WAIT_ACC: begin
                    if (acc_valid) begin
                        if (acc_better) begin
                            result_value_q <= acc_value;
                            result_index_q <= n_q;
                        end
                        if (n_q == N_LAST) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            n_q         <= n_q + 4'd1;
                            state_q     <= PREP;
                            mac_clear_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign issue_tag = {r_enable_q, h_q, last_issue};

    nn_read_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (clear),
        .tag_i   (issue_tag),
        .tag_o   (beat_tag)
    );

    assign r_enable       = r_enable_q;
    assign weight_address = waddr_q;
    assign pixel_address1 = p_q;
    assign pixel_address2 = p_q;
    assign mac_clear      = mac_clear_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result_index   = result_index_q;
    assign result_value   = result_value_q;

    // Data buses are gated so nothing leaks downstream between beats.
    assign mac_valid   = beat_tag.vld;
    assign mac_last    = beat_tag.vld & beat_tag.last;
    assign mac_weights = beat_tag.vld ? weight_value : 32'd0;
    assign mac_pixels  = !beat_tag.vld ? 16'd0 : (beat_tag.half ? pixel_value2 : pixel_value1);

endmodule

// File: tb/tb_nn_compute_sequencer.sv
// Directed bench for nn_compute_sequencer with SRAM and MAC models (READ_LATENCY=3).
module tb_nn_compute_sequencer;

    localparam int RL    = 3;
    localparam int ACC_W = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             clear;
    logic             r_enable;
    logic [11:0]      weight_address;
    logic [9:0]       pixel_address1;
    logic [9:0]       pixel_address2;
    logic [31:0]      weight_value;
    logic [15:0]      pixel_value1;
    logic [15:0]      pixel_value2;
    logic             mac_clear;
    logic             mac_valid;
    logic             mac_last;
    logic [15:0]      mac_pixels;
    logic [31:0]      mac_weights;
    logic             acc_valid;
    logic [ACC_W-1:0] acc_value;
    logic             busy;
    logic             done;
    logic [3:0]       result_index;
    logic [ACC_W-1:0] result_value;

    always #5 clk = ~clk;

    nn_compute_sequencer #(
        .READ_LATENCY (RL),
        .ACC_W        (ACC_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .clear          (clear),
        .r_enable       (r_enable),
        .weight_address (weight_address),
        .pixel_address1 (pixel_address1),
        .pixel_address2 (pixel_address2),
        .weight_value   (weight_value),
        .pixel_value1   (pixel_value1),
        .pixel_value2   (pixel_value2),
        .mac_clear      (mac_clear),
        .mac_valid      (mac_valid),
        .mac_last       (mac_last),
        .mac_pixels     (mac_pixels),
        .mac_weights    (mac_weights),
        .acc_valid      (acc_valid),
        .acc_value      (acc_value),
        .busy           (busy),
        .done           (done),
        .result_index   (result_index),
        .result_value   (result_value)
    );

    // SRAM model: address sampled with the read, data valid RL cycles later.
    logic [31:0] wmem [4096];
    logic [15:0] px1, px2;
    logic [11:0] wa_d [RL];

    always @(posedge clk) begin
        wa_d[0] <= weight_address;
        for (int i = 1; i < RL; i++) wa_d[i] <= wa_d[i-1];
    end

    assign weight_value = wmem[wa_d[RL-1]];
    assign pixel_value1 = px1;
    assign pixel_value2 = px2;

    // MAC model: sum of 16-bit signed weight x 8-bit pixel, sum offered 5 cycles after last.
    int mac_acc;
    int acc_r;
    int acc_cnt;

    function automatic int beat_prod(input logic [31:0] w, input logic [15:0] px);
        return int'($signed(w[15:0]))  * int'({24'd0, px[7:0]}) +
               int'($signed(w[31:16])) * int'({24'd0, px[15:8]});
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_acc <= 0;
            acc_r   <= 0;
            acc_cnt <= 0;
        end else begin
            if (acc_cnt != 0) acc_cnt <= acc_cnt - 1;
            if (mac_clear) begin
                mac_acc <= 0;
            end else if (mac_valid) begin
                mac_acc <= mac_acc + beat_prod(mac_weights, mac_pixels);
                if (mac_last) begin
                    acc_r   <= mac_acc + beat_prod(mac_weights, mac_pixels);
                    acc_cnt <= 5;
                end
            end
        end
    end

    assign acc_valid = (acc_cnt == 1);
    assign acc_value = acc_r;

    // Protocol monitor.
    logic        mon_clr;
    int          cyc = 0;
    int          beats_total = 0;
    int          issue_cnt, addr_err, beat_in_n, beat_err, pix_err;
    int          neurons_seen, acc_seen, first_ren, first_beat;
    logic [11:0] last_waddr;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_valid) beats_total <= beats_total + 1;
        if (mon_clr) begin
            issue_cnt    <= 0;
            addr_err     <= 0;
            beat_in_n    <= 0;
            beat_err     <= 0;
            pix_err      <= 0;
            neurons_seen <= 0;
            acc_seen     <= 0;
            first_ren    <= -1;
            first_beat   <= -1;
            last_waddr   <= '0;
        end else begin
            if (r_enable) begin
                if (weight_address !== 12'(issue_cnt) ||
                    pixel_address1 !== 10'((issue_cnt % 392) / 2) ||
                    pixel_address2 !== pixel_address1)
                    addr_err <= addr_err + 1;
                issue_cnt  <= issue_cnt + 1;
                last_waddr <= weight_address;
                if (first_ren < 0) first_ren <= cyc;
            end
            if (acc_valid) acc_seen <= acc_seen + 1;
            if (mac_valid) begin
                if (first_beat < 0) first_beat <= cyc;
                if (mac_last !== (beat_in_n == 391)) beat_err <= beat_err + 1;
                if (mac_pixels !== (beat_in_n[0] ? px2 : px1)) pix_err <= pix_err + 1;
                beat_in_n <= mac_last ? 0 : beat_in_n + 1;
                if (mac_last) neurons_seen <= neurons_seen + 1;
            end
        end
    end

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start   = 1'b1;
        mon_clr = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 8000 && done !== 1'b1; i++) @(negedge clk);
        chk(tag, 32'(done), 1);
    endtask

    task automatic fill_uniform(input logic [31:0] v);
        for (int a = 0; a < 4096; a++) wmem[a] = v;
    endtask

    int b0;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        clear   = 1'b0;
        mon_clr = 1'b1;
        px1     = 16'h0101;
        px2     = 16'h0101;
        fill_uniform(32'h0001_0001);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ren", 32'(r_enable), 0);
        chk("rst_waddr", 32'(weight_address), 0);
        chk("rst_mac_valid", 32'(mac_valid), 0);
        chk("rst_result", 32'(result_value), 0);
        reset_n = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;

        // Uniform weights: every neuron sums to 784, tie keeps index 0.
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        wait_done("t1_done");
        chk("t1_index", 32'(result_index), 0);
        chk("t1_value", result_value, 784);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_neurons", 32'(neurons_seen), 10);
        chk("t1_issues", 32'(issue_cnt), 3920);
        chk("t1_last_waddr", 32'(last_waddr), 3919);
        chk("t1_addr_err", 32'(addr_err), 0);
        chk("t1_beat_err", 32'(beat_err), 0);

        // Neuron k weights k+1: sums 784*(k+1), maximum at neuron 9.
        for (int a = 0; a < 3920; a++) wmem[a] = {16'(a / 392 + 1), 16'(a / 392 + 1)};
        pulse_start();
        wait_done("t2_done");
        chk("t2_index", 32'(result_index), 9);
        chk("t2_value", result_value, 7840);
        chk("t2_neurons", 32'(neurons_seen), 10);
        chk("t2_addr_err", 32'(addr_err), 0);
        chk("t2_beat_err", 32'(beat_err), 0);
        chk("t2_last_waddr", 32'(last_waddr), 3919);

        // Distinct pixel words; neuron 0 negative (-1176), 5 and 7 tie at 2352, rest 1176.
        px1 = 16'h0101;
        px2 = 16'h0202;
        fill_uniform(32'h0001_0001);
        for (int a = 0; a < 392; a++) wmem[a] = 32'hFFFF_FFFF;
        for (int a = 5 * 392; a < 6 * 392; a++) wmem[a] = 32'h0002_0002;
        for (int a = 7 * 392; a < 8 * 392; a++) wmem[a] = 32'h0002_0002;
        pulse_start();
        wait_done("t3_done");
        chk("t3_index", 32'(result_index), 5);
        chk("t3_value", result_value, 2352);
        chk("t3_pix_err", 32'(pix_err), 0);
        chk("t3_first_latency", 32'(first_beat - first_ren), 3);
        chk("t3_beat_err", 32'(beat_err), 0);

        // Clear at neuron 4, beat 100.
        pulse_start();
        for (int i = 0; i < 3000 && !(neurons_seen == 4 && beat_in_n >= 100); i++) @(negedge clk);
        chk("t4_reach_neuron", 32'(neurons_seen), 4);
        chk("t4_mid_index", 32'(result_index), 1);
        chk("t4_mid_value", result_value, 1176);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(done), 0);
        chk("t4_result", result_value, 0);
        chk("t4_ren", 32'(r_enable), 0);
        b0 = beats_total;
        repeat (20) @(negedge clk);
        chk("t4_no_beats", 32'(beats_total), 32'(b0));
        pulse_start();
        for (int i = 0; i < 10 && r_enable !== 1'b1; i++) @(negedge clk);
        chk("t4_restart_ren", 32'(r_enable), 1);
        chk("t4_restart_waddr", 32'(weight_address), 0);
        wait_done("t4_done_pass");
        chk("t4_index", 32'(result_index), 5);
        chk("t4_neurons", 32'(neurons_seen), 10);

        // Start and clear together, then an extra start while busy.
        @(negedge clk);
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        b0 = beats_total;
        repeat (10) @(negedge clk);
        chk("t5_idle_beats", 32'(beats_total), 32'(b0));
        chk("t5_idle_ren", 32'(r_enable), 0);
        pulse_start();
        repeat (300) @(negedge clk);
        chk("t5_busy_mid", 32'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_done_pass");
        b0 = beats_total;
        repeat (50) @(negedge clk);
        chk("t5_no_second_pass", 32'(beats_total), 32'(b0));
        chk("t5_busy_after", 32'(busy), 0);
        chk("t5_acc_seen", 32'(acc_seen), 10);
        chk("t5_neurons", 32'(neurons_seen), 10);

        // Asynchronous reset mid-STREAM.
        pulse_start();
        repeat (50) @(negedge clk);
        chk("t6_streaming", 32'(r_enable), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_ren", 32'(r_enable), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_waddr", 32'(weight_address), 0);
        chk("t6_paddr", 32'(pixel_address1), 0);
        chk("t6_mac_valid", 32'(mac_valid), 0);
        chk("t6_result", result_value, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        b0 = beats_total;
        repeat (30) @(negedge clk);
        chk("t6_no_beats", 32'(beats_total), 32'(b0));
        chk("t6_busy_after", 32'(busy), 0);
        pulse_start();
        wait_done("t6_done_pass");
        chk("t6_index", 32'(result_index), 5);
        chk("t6_value", result_value, 2352);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
